// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM bus arbiter: FSM state encoding and owner codes.
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RFC_GNT  = 3'd1,
    ST_RFC_WAIT = 3'd2,
    ST_OWN0     = 3'd3,
    ST_OWN1     = 3'd4
  } state_e;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_C0   = 2'd1;
  localparam logic [1:0] SEL_C1   = 2'd2;
  localparam logic [1:0] SEL_RFC  = 2'd3;

  function automatic logic [1:0] sel_of(input state_e s);
    case (s)
      ST_RFC_GNT, ST_RFC_WAIT: return SEL_RFC;
      ST_OWN0:                 return SEL_C0;
      ST_OWN1:                 return SEL_C1;
      default:                 return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hold_cnt.sv
// Saturating ownership hold counter; o_at_max looks at the value the counter takes after this cycle.
module hold_cnt #(
  parameter int HOLD_MAX = 64,
  parameter int CNT_BITS = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clear,
  input  logic i_en,
  output logic o_at_max
);

  localparam logic [CNT_BITS-1:0] MAX_VAL = CNT_BITS'(HOLD_MAX);

  logic [CNT_BITS-1:0] r_cnt;
  logic [CNT_BITS-1:0] w_cnt_nxt;
  logic                w_sat;

  assign w_sat = (r_cnt >= MAX_VAL);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clear)
      w_cnt_nxt = '0;
    else if (i_en && !w_sat)
      w_cnt_nxt = r_cnt + CNT_BITS'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i)
      r_cnt <= '0;
    else
      r_cnt <= w_cnt_nxt;
  end

  assign o_at_max = (w_cnt_nxt >= MAX_VAL);

endmodule

// File: rtl/sdram_arb.sv
// SDRAM bus arbiter: refresh first, then two clients, with a yield request after a long hold.
// Define ARB_RR_EN to alternate client ties; otherwise client 0 always wins ties.
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int HOLD_MAX = 64,
  parameter int CNT_BITS = 7
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rfc_req_i,
  output logic       rfc_gnt_o,
  input  logic       rfc_busy_i,
  input  logic       c0_req_i,
  output logic       c0_gnt_o,
  input  logic       c1_req_i,
  output logic       c1_gnt_o,
  output logic       yield_o,
  output logic [1:0] sel_o
);

  state_e     r_state;
  state_e     w_next;
  logic       w_tie_c1;
  logic       w_in_own;
  logic       w_enter_own;
  logic       w_stay_own;
  logic       w_at_max;
  logic       r_rfc_gnt;
  logic       r_c0_gnt;
  logic       r_c1_gnt;
  logic       r_yield;
  logic [1:0] r_sel;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (rfc_req_i)                w_next = ST_RFC_GNT;
        else if (c0_req_i && c1_req_i) w_next = w_tie_c1 ? ST_OWN1 : ST_OWN0;
        else if (c0_req_i)            w_next = ST_OWN0;
        else if (c1_req_i)            w_next = ST_OWN1;
      end
      ST_RFC_GNT:  w_next = ST_RFC_WAIT;
      ST_RFC_WAIT: if (!rfc_busy_i) w_next = ST_IDLE;
      ST_OWN0:     if (!c0_req_i)   w_next = ST_IDLE;
      ST_OWN1:     if (!c1_req_i)   w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  assign w_in_own    = (r_state == ST_OWN0) || (r_state == ST_OWN1);
  assign w_enter_own = (r_state == ST_IDLE) && ((w_next == ST_OWN0) || (w_next == ST_OWN1));
  assign w_stay_own  = w_in_own && (w_next == r_state);

`ifdef ARB_RR_EN
  // Records which client won last; a tie goes to the other one.
  logic r_last_c1;

  always_ff @(posedge clk_i) begin
    if (!rst_i)
      r_last_c1 <= 1'b1;
    else if (w_enter_own)
      r_last_c1 <= (w_next == ST_OWN1);
  end

  assign w_tie_c1 = !r_last_c1;
`else
  assign w_tie_c1 = 1'b0;
`endif

  hold_cnt #(
    .HOLD_MAX (HOLD_MAX),
    .CNT_BITS (CNT_BITS)
  ) u_hold_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_clear  (w_enter_own),
    .i_en     (w_in_own),
    .o_at_max (w_at_max)
  );

  // Outputs are decoded from the next state so each register matches the state it accompanies.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state   <= ST_IDLE;
      r_rfc_gnt <= 1'b0;
      r_c0_gnt  <= 1'b0;
      r_c1_gnt  <= 1'b0;
      r_yield   <= 1'b0;
      r_sel     <= SEL_NONE;
    end else begin
      r_state   <= w_next;
      r_rfc_gnt <= (w_next == ST_RFC_GNT);
      r_c0_gnt  <= (w_next == ST_OWN0);
      r_c1_gnt  <= (w_next == ST_OWN1);
      r_yield   <= w_stay_own && rfc_req_i && w_at_max;
      r_sel     <= sel_of(w_next);
    end
  end

  assign rfc_gnt_o = r_rfc_gnt;
  assign c0_gnt_o  = r_c0_gnt;
  assign c1_gnt_o  = r_c1_gnt;
  assign yield_o   = r_yield;
  assign sel_o     = r_sel;

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb; outputs are sampled on the falling edge, inputs driven there too.
module tb_sdram_arb;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       rfc_req_i;
  logic       rfc_gnt_o;
  logic       rfc_busy_i;
  logic       c0_req_i;
  logic       c0_gnt_o;
  logic       c1_req_i;
  logic       c1_gnt_o;
  logic       yield_o;
  logic [1:0] sel_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Output vector: {rfc_gnt, c0_gnt, c1_gnt, yield, sel[1:0]}
  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_RFCG  = 6'b100011;
  localparam logic [5:0] O_RFCW  = 6'b000011;
  localparam logic [5:0] O_OWN0  = 6'b010001;
  localparam logic [5:0] O_OWN1  = 6'b001010;
  localparam logic [5:0] O_OWN1Y = 6'b001110;

  always #5 clk = ~clk;

  sdram_arb #(
    .HOLD_MAX (64),
    .CNT_BITS (7)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .rfc_req_i  (rfc_req_i),
    .rfc_gnt_o  (rfc_gnt_o),
    .rfc_busy_i (rfc_busy_i),
    .c0_req_i   (c0_req_i),
    .c0_gnt_o   (c0_gnt_o),
    .c1_req_i   (c1_req_i),
    .c1_gnt_o   (c1_gnt_o),
    .yield_o    (yield_o),
    .sel_o      (sel_o)
  );

  function automatic logic [5:0] outs();
    return {rfc_gnt_o, c0_gnt_o, c1_gnt_o, yield_o, sel_o};
  endfunction

  task automatic test_reset();
    rst_i = 1'b0; rfc_req_i = 1'b1; rfc_busy_i = 1'b1; c0_req_i = 1'b1; c1_req_i = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (outs() !== O_IDLE) begin
        n_bad++; $display("FAIL reset_hold[%0d]: got %b want %b", k, outs(), O_IDLE);
      end
    end
    rst_i = 1'b1; rfc_req_i = 1'b0; rfc_busy_i = 1'b0; c0_req_i = 1'b0; c1_req_i = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (outs() !== O_IDLE) begin
        n_bad++; $display("FAIL reset_release[%0d]: got %b want %b", k, outs(), O_IDLE);
      end
    end
  endtask

  task automatic test_refresh_alone();
    logic [5:0] exp [1:6];
    int gnt_cycles;
    int sel3_cycles;
    exp = '{O_RFCG, O_RFCW, O_RFCW, O_RFCW, O_RFCW, O_IDLE};
    gnt_cycles = 0; sel3_cycles = 0;
    rfc_req_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (outs() !== exp[k]) begin
        n_bad++; $display("FAIL refresh_alone[%0d]: got %b want %b", k, outs(), exp[k]);
      end
      if (rfc_gnt_o) gnt_cycles++;
      if (sel_o == 2'd3) sel3_cycles++;
      if (k == 1) rfc_req_i = 1'b0;
      if (k == 2) rfc_busy_i = 1'b1;
      if (k == 5) rfc_busy_i = 1'b0;
    end
    n_cmp++;
    if (gnt_cycles != 1) begin
      n_bad++; $display("FAIL refresh_gnt_len: got %0d want 1", gnt_cycles);
    end
    n_cmp++;
    if (sel3_cycles != 5) begin
      n_bad++; $display("FAIL refresh_sel3_len: got %0d want 5", sel3_cycles);
    end
  endtask

  task automatic test_simultaneous();
    logic [5:0] exp [1:8];
    exp = '{O_RFCG, O_RFCW, O_IDLE, O_OWN0, O_OWN0, O_IDLE, O_OWN1, O_IDLE};
    rfc_req_i = 1'b1; c0_req_i = 1'b1; c1_req_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if (outs() !== exp[k]) begin
        n_bad++; $display("FAIL simultaneous[%0d]: got %b want %b", k, outs(), exp[k]);
      end
      if (k == 1) rfc_req_i = 1'b0;
      if (k == 5) c0_req_i = 1'b0;
      if (k == 7) c1_req_i = 1'b0;
    end
  endtask

  task automatic test_yield();
    logic [5:0] exp [1:4];
    exp = '{O_OWN1, O_IDLE, O_RFCG, O_RFCW};
    c1_req_i = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      n_cmp++;
      if (outs() !== ((k >= 65) ? O_OWN1Y : O_OWN1)) begin
        n_bad++; $display("FAIL yield_own1[%0d]: got %b want %b", k, outs(),
                          (k >= 65) ? O_OWN1Y : O_OWN1);
      end
      if (k == 10)  rfc_req_i = 1'b1;
      if (k == 100) c1_req_i = 1'b0;
    end
    // After the owner drops: one IDLE, then the refresh grant pulse.
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (outs() !== exp[k]) begin
        n_bad++; $display("FAIL yield_after[%0d]: got %b want %b", k, outs(), exp[k]);
      end
      if (k == 3) rfc_req_i = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if (outs() !== O_IDLE) begin
      n_bad++; $display("FAIL yield_end: got %b want %b", outs(), O_IDLE);
    end
  endtask

  task automatic test_tie_order();
    int   exp_who [4];
    int   who [4];
    int   n_exp;
    int   ng;
    int   run0;
    int   run1;
    logic p0;
    logic p1;
    logic [5:0] prev;
`ifdef ARB_RR_EN
    exp_who = '{0, 1, 0, 1}; n_exp = 4;
`else
    exp_who = '{0, 0, 0, 0}; n_exp = 3;
`endif
    who = '{-1, -1, -1, -1};
    ng = 0; run0 = 0; run1 = 0; p0 = 1'b0; p1 = 1'b0; prev = O_IDLE;
    c0_req_i = 1'b1; c1_req_i = 1'b1;
    for (int cyc = 0; cyc < 80 && ng < n_exp; cyc++) begin
      @(negedge clk);
      if ((c0_gnt_o && !p0) || (c1_gnt_o && !p1)) begin
        who[ng] = c1_gnt_o ? 1 : 0;
        ng++;
        n_cmp++;
        if (prev !== O_IDLE) begin
          n_bad++; $display("FAIL tie_gap[%0d]: got %b want %b", ng, prev, O_IDLE);
        end
      end
      if (!c0_gnt_o && p0) begin
        n_cmp++;
        if (run0 != 4) begin
          n_bad++; $display("FAIL tie_len0: got %0d want 4", run0);
        end
        run0 = 0;
      end
      if (!c1_gnt_o && p1) begin
        n_cmp++;
        if (run1 != 4) begin
          n_bad++; $display("FAIL tie_len1: got %0d want 4", run1);
        end
        run1 = 0;
      end
      if (c0_gnt_o) run0++;
      if (c1_gnt_o) run1++;
      c0_req_i = !(c0_gnt_o && run0 == 4);
      c1_req_i = !(c1_gnt_o && run1 == 4);
      p0 = c0_gnt_o; p1 = c1_gnt_o; prev = outs();
    end
    n_cmp++;
    if (ng != n_exp) begin
      n_bad++; $display("FAIL tie_timeout: got %0d grants want %0d", ng, n_exp);
    end
    for (int i = 0; i < n_exp; i++) begin
      n_cmp++;
      if (who[i] != exp_who[i]) begin
        n_bad++; $display("FAIL tie_order[%0d]: got c%0d want c%0d", i, who[i], exp_who[i]);
      end
    end
    c0_req_i = 1'b0; c1_req_i = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (outs() !== O_IDLE) begin
      n_bad++; $display("FAIL tie_release: got %b want %b", outs(), O_IDLE);
    end
  endtask

  task automatic test_reset_mid();
    // Inputs per step: {rst_i, rfc_req_i, rfc_busy_i, c0_req_i, c1_req_i}
    logic [4:0] in_v [0:15];
    logic [5:0] exp  [1:16];
    in_v = '{5'b11000, 5'b10100, 5'b00100, 5'b11010, 5'b10010, 5'b10010, 5'b10010, 5'b10000,
             5'b10001, 5'b10001, 5'b00001, 5'b10011, 5'b10000,
             5'b01000, 5'b10000, 5'b10000};
    exp  = '{O_RFCG, O_RFCW, O_IDLE, O_RFCG, O_RFCW, O_IDLE, O_OWN0, O_IDLE,
             O_OWN1, O_OWN1, O_IDLE, O_OWN0, O_IDLE,
             O_IDLE, O_IDLE, O_IDLE};
    {rst_i, rfc_req_i, rfc_busy_i, c0_req_i, c1_req_i} = in_v[0];
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      n_cmp++;
      if (outs() !== exp[k]) begin
        n_bad++; $display("FAIL reset_mid[%0d]: got %b want %b", k, outs(), exp[k]);
      end
      if (k < 16) {rst_i, rfc_req_i, rfc_busy_i, c0_req_i, c1_req_i} = in_v[k];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; rfc_req_i = 1'b0; rfc_busy_i = 1'b0; c0_req_i = 1'b0; c1_req_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_refresh_alone();
    test_simultaneous();
    test_yield();
    test_tie_order();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
